sync_fifo_buffer: RTL and testbench



---
 rtl/sync_fifo_buffer.sv | 85 ++++++++
 tb/tb_sync_fifo_buffer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_buffer.sv
// Single-clock FIFO with a registered pop output that is zero on every cycle without a pop.
// A push and a pop in the same cycle occur together only when both succeed.
module sync_fifo_buffer #(
  parameter int unsigned width                = 8,
  parameter int unsigned length_as_power_of_2 = 4
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [width-1:0] data_in,
  input  logic             read_enable,
  input  logic             write_enable,
  output logic [width-1:0] data_out,
  output logic             full,
  output logic             empty
);

  localparam int unsigned Aw    = length_as_power_of_2;
  localparam int unsigned Depth = 2 ** length_as_power_of_2;

  logic [width-1:0] mem_q [Depth];
  logic [Aw-1:0]    head_q, head_d;
  logic [Aw-1:0]    tail_q, tail_d;
  logic [Aw:0]      count_q, count_d;
  logic [width-1:0] data_out_q, data_out_d;

  logic push_ok, pop_ok, do_push, do_pop;

  assign full     = (count_q == (Aw+1)'(Depth));
  assign empty    = (count_q == '0);
  assign data_out = data_out_q;

  assign push_ok = read_enable & ~full;
  assign pop_ok  = write_enable & ~empty;

  // With both requests raised, a failure of either side cancels the whole transaction.
  always_comb begin
    do_push = push_ok;
    do_pop  = pop_ok;
    if (read_enable && write_enable) begin
      do_push = push_ok & pop_ok;
      do_pop  = push_ok & pop_ok;
    end
  end

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    data_out_d = '0;
    if (do_pop) begin
      data_out_d = mem_q[head_q];
      head_d     = head_q + Aw'(1);
    end
    if (do_push) begin
      tail_d = tail_q + Aw'(1);
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + (Aw+1)'(1);
      2'b01:   count_d = count_q - (Aw+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      data_out_q <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
    end
  end

  // Storage needs no reset; only occupancy decides what is readable.
  always_ff @(posedge clock) begin
    if (resetn && do_push) begin
      mem_q[tail_q] <= data_in;
    end
  end

endmodule

// File: tb/tb_sync_fifo_buffer.sv
// Bench for sync_fifo_buffer at depth 4; a queue scoreboard supplies expected pop data.
module tb_sync_fifo_buffer;

  localparam int Depth = 4;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] data_in = '0;
  logic       read_enable = 1'b0;
  logic       write_enable = 1'b0;
  logic [7:0] data_out;
  logic       full, empty;

  int checks = 0;
  int passed = 0;
  logic [7:0] sb_q[$];

  sync_fifo_buffer #(
    .width               (8),
    .length_as_power_of_2(2)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .data_in     (data_in),
    .read_enable (read_enable),
    .write_enable(write_enable),
    .data_out    (data_out),
    .full        (full),
    .empty       (empty)
  );

  always #5 clock = ~clock;

  // Drives one cycle of requests, advances the scoreboard, samples 1 time unit after the edge.
  task automatic drive_cycle(input logic rd, input logic wr, input logic [7:0] din,
                             output logic [7:0] exp_dout);
    logic m_full, m_empty, p_ok, q_ok;
    read_enable  = rd;
    write_enable = wr;
    data_in      = din;
    m_full  = (sb_q.size() == Depth);
    m_empty = (sb_q.size() == 0);
    p_ok = rd & ~m_full;
    q_ok = wr & ~m_empty;
    if (rd && wr && !(p_ok && q_ok)) begin
      p_ok = 1'b0;
      q_ok = 1'b0;
    end
    exp_dout = '0;
    if (q_ok) exp_dout = sb_q.pop_front();
    if (p_ok) sb_q.push_back(din);
    @(posedge clock);
    #1;
    read_enable  = 1'b0;
    write_enable = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] e;
    resetn = 1'b0;
    @(posedge clock);
    #1;
    resetn = 1'b1;
    sb_q.delete();
    drive_cycle(1'b0, 1'b0, 8'h00, e);
    checks++;
    if (data_out !== 8'h00) $display("FAIL reset_dout: got %h expected 00", data_out);
    else passed++;
    checks++;
    if (full !== 1'b0 || empty !== 1'b1)
      $display("FAIL reset_flags: got full=%b empty=%b expected full=0 empty=1", full, empty);
    else passed++;
  endtask

  task automatic test_fill_drain();
    logic [7:0] e;
    for (int i = 1; i <= 16; i++) begin
      drive_cycle(1'b1, 1'b0, 8'(i), e);
      checks++;
      if (data_out !== 8'h00 || empty !== 1'b0 || full !== (i >= 4))
        $display("FAIL fill_%0d: got dout=%h full=%b empty=%b expected dout=00 full=%b empty=0",
                 i, data_out, full, empty, (i >= 4));
      else passed++;
    end
    for (int i = 0; i < 16; i++) begin
      drive_cycle(1'b0, 1'b0, 8'h00, e);
      checks++;
      if (data_out !== 8'h00 || full !== 1'b1 || empty !== 1'b0)
        $display("FAIL hold_full_%0d: got dout=%h full=%b empty=%b expected 00/1/0",
                 i, data_out, full, empty);
      else passed++;
    end
    for (int i = 1; i <= 4; i++) begin
      drive_cycle(1'b0, 1'b1, 8'h00, e);
      checks++;
      if (data_out !== 8'(i) || data_out !== e || full !== 1'b0 || empty !== (i == 4))
        $display("FAIL drain_%0d: got dout=%h full=%b empty=%b expected dout=%h full=0 empty=%b",
                 i, data_out, full, empty, 8'(i), (i == 4));
      else passed++;
    end
    for (int i = 0; i < 16; i++) begin
      drive_cycle(1'b0, 1'b1, 8'h00, e);
      checks++;
      if (data_out !== 8'h00 || full !== 1'b0 || empty !== 1'b1)
        $display("FAIL underflow_%0d: got dout=%h full=%b empty=%b expected 00/0/1",
                 i, data_out, full, empty);
      else passed++;
    end
  endtask

  task automatic test_wrap();
    logic [7:0] e;
    int pushes[4] = '{3, 0, 3, 0};
    int pops[4]   = '{0, 2, 0, 4};
    logic [7:0] v = 8'h30;
    for (int s = 0; s < 4; s++) begin
      for (int k = 0; k < pushes[s]; k++) begin
        v++;
        drive_cycle(1'b1, 1'b0, v, e);
      end
      for (int k = 0; k < pops[s]; k++) begin
        drive_cycle(1'b0, 1'b1, 8'h00, e);
        checks++;
        if (data_out !== e || e === 8'h00)
          $display("FAIL wrap_pop_s%0d_%0d: got %h expected %h", s, k, data_out, e);
        else passed++;
      end
    end
    checks++;
    if (empty !== 1'b1 || full !== 1'b0)
      $display("FAIL wrap_end_flags: got full=%b empty=%b expected full=0 empty=1", full, empty);
    else passed++;
  endtask

  task automatic test_simultaneous();
    logic [7:0] e;
    drive_cycle(1'b1, 1'b1, 8'h55, e);
    checks++;
    if (data_out !== 8'h00 || empty !== 1'b1 || full !== 1'b0)
      $display("FAIL both_empty: got dout=%h full=%b empty=%b expected 00/0/1",
               data_out, full, empty);
    else passed++;
    drive_cycle(1'b1, 1'b0, 8'h21, e);
    drive_cycle(1'b1, 1'b0, 8'h22, e);
    drive_cycle(1'b1, 1'b1, 8'h09, e);
    checks++;
    if (data_out !== 8'h21 || full !== 1'b0 || empty !== 1'b0)
      $display("FAIL both_two: got dout=%h full=%b empty=%b expected 21/0/0",
               data_out, full, empty);
    else passed++;
    drive_cycle(1'b1, 1'b0, 8'h23, e);
    drive_cycle(1'b1, 1'b0, 8'h24, e);
    checks++;
    if (full !== 1'b1)
      $display("FAIL both_count_kept: got full=%b expected 1", full);
    else passed++;
    drive_cycle(1'b1, 1'b1, 8'h77, e);
    checks++;
    if (data_out !== 8'h00 || full !== 1'b1 || empty !== 1'b0)
      $display("FAIL both_full: got dout=%h full=%b empty=%b expected 00/1/0",
               data_out, full, empty);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b0, 1'b1, 8'h00, e);
      checks++;
      if (data_out !== e)
        $display("FAIL both_drain_%0d: got %h expected %h", i, data_out, e);
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] e;
    drive_cycle(1'b1, 1'b0, 8'hA1, e);
    drive_cycle(1'b1, 1'b0, 8'hA2, e);
    drive_cycle(1'b1, 1'b0, 8'hA3, e);
    write_enable = 1'b1;
    resetn = 1'b0;
    @(posedge clock);
    #1;
    resetn = 1'b1;
    write_enable = 1'b0;
    sb_q.delete();
    checks++;
    if (empty !== 1'b1 || full !== 1'b0 || data_out !== 8'h00)
      $display("FAIL reset_mid: got dout=%h full=%b empty=%b expected 00/0/1",
               data_out, full, empty);
    else passed++;
    drive_cycle(1'b0, 1'b1, 8'h00, e);
    checks++;
    if (data_out !== 8'h00 || empty !== 1'b1)
      $display("FAIL reset_mid_pop: got dout=%h empty=%b expected 00/1", data_out, empty);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_wrap();
    test_simultaneous();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule
